qam_herm_mapper: RTL and testbench
==================================

// Module: qam_herm_mapper
// PURPOSE
//  Parametrised successor of the fixed 16-QAM mapper. Runtime-selectable QPSK/16-QAM/64-QAM
//  serial-bit mapper that builds one Hermitian-symmetric frame of NFFT samples per OFDM symbol.
//  The frame feeds the IFFT sink, so the IFFT output is real-valued for the VLC/DCO-OFDM transmit path.
//  Single-clock design; one frame buffer; input stalls while a frame is being emitted.
// PARAMETERS
//  NFFT   128  frame length in samples; power of 2, >=8; buffer depth is NFFT/2 symbols
//  W      8    signed width of I_real/Q_imag; >=4
// PORTS
//  clk         in   1  sole clock, all logic on posedge
//  reset       in   1  asynchronous, active-high; clears all state
//  mode        in   2  0=QPSK, 1=16-QAM, 2=64-QAM, 3=treated as 16-QAM; latched at frame start
//  data_in     in   1  serial data bit
//  data_valid  in   1  data_in valid this cycle
//  data_ready  out  1  block accepts data_in (bit taken when data_valid&&data_ready)
//  I_real      out  W  signed real part of current frame sample
//  Q_imag      out  W  signed imaginary part of current frame sample
//  sink_ready  in   1  IFFT ready; sample consumed when sink_valid&&sink_ready
//  sink_valid  out  1  I_real/Q_imag/sop/eop valid
//  sink_sop    out  1  high with sample k=0
//  sink_eop    out  1  high with sample k=NFFT-1
// BEHAVIOUR
//  - Reset values: I_real=0, Q_imag=0, sink_valid/sop/eop=0, data_ready=0. State goes to FILL;
//    data_ready rises on the first clk edge after reset deasserts.
//  - States: FILL (data_ready=1, sink_valid=0) -> EMIT (data_ready=0) -> FILL.
//  - mode is latched on entry to FILL; mode changes during a frame are ignored.
//  - Bits per symbol B = 2/4/6. The first B/2 accepted bits form the I group and the next B/2
//    form the Q group; the first bit received is the MSB.
//  - Axis map: group MSB is the sign (1=+, 0=-). Remaining bits g are Gray-coded:
//    mag = 2*gray2bin(g)+1 (QPSK has no g, so mag=1). 16-QAM: 00->-1, 01->-3, 11->+3, 10->+1.
//  - Each completed symbol is written to buffer index s = 0..S-1, where S = NFFT/2.
//  - The write of symbol S-1 moves the state to EMIT. sink_valid rises on the 2nd clk edge
//    after the acceptance edge of the frame's last bit.
//  - EMIT sample k, with X_s=(re,im):
//    k=0 -> (re X0, 0); 1..S-1 -> X_k; k=S -> (im X0, 0); S+1..NFFT-1 -> (re X_{NFFT-k}, -im X_{NFFT-k}).
//  - Negation is two's complement at W bits; values never exceed +/-7, so no saturation is needed.
//  - Backpressure: while sink_valid && !sink_ready, all outputs hold. No sample is skipped or duplicated.
//  - On the eop handshake: sink_valid=0 and data_ready=1 on the next edge, and a new mode is latched.
//  - Frame counter wraps only at an eop handshake. Bits offered during EMIT are not accepted.
//  - Reset mid-frame (FILL or EMIT) discards the partial frame. No stale sample may reappear.
// CONFIGURATION
//  QAM_DC_NULL_EN defined:
//  - Subcarrier 0 carries no data: S = NFFT/2-1 symbols are stored, at indices 1..NFFT/2-1.
//  - Samples k=0 and k=NFFT/2 output (0,0).
//  QAM_DC_NULL_EN undefined: behaviour exactly as above (X0 is taken from data).
// STRUCTURE
//  - Package qam_map_pkg holds:
//    - MODE_QPSK/MODE_16QAM/MODE_64QAM encodings
//    - bits-per-symbol function
//    - FILL/EMIT state encoding
//    - axis-map function (sign + Gray -> signed W)
//  - Sub-module qam_sym_buf: NFFT/2 x 2W register array, one write port, combinational read port.
//  - Top-level holds the shifter, FSM, sample counter and the conjugate/mirror output register.
// TESTING
//  1. NFFT=8, mode=1, bits 0000_1111_1010_0101 -> X0..3=(-1,-1),(3,3),(1,1),(-3,-3).
//     Expected samples: (-1,0),(3,3),(1,1),(-3,-3),(-1,0),(-3,3),(1,-1),(3,-3).
//     sop on k=0, eop on k=7.
//  2. mode=2, first symbol bits 111010 -> X0=(+5,-7).
//     mode=0, bits 10 -> (+1,-1). mode=3 behaves identically to mode=1.
//  3. sink_ready low for 3 cycles while k=3 is presented -> the k=3 sample holds.
//     Then k=4..7 follow in order; data_ready stays 0 throughout.
//  4. mode switched from 1 to 2 mid-FILL -> current frame still 16-QAM; next frame 64-QAM.
//  5. reset pulsed during EMIT at k=5 -> all outputs 0 immediately.
//     data_ready=1 one edge after release; the next frame starts at s=0.
//  6. QAM_DC_NULL_EN, NFFT=8, mode=1, 12 bits -> k=0 and k=4 are (0,0).
//     k=1..3 are the data; k=5..7 are their conjugate mirror.

Source files
------------

// File: rtl/qam_map_pkg.sv
// qam_map_pkg: mode encodings, FSM states and constellation helpers
// shared by the Hermitian QAM mapper.
package qam_map_pkg;

  localparam logic [1:0] MODE_QPSK  = 2'd0;
  localparam logic [1:0] MODE_16QAM = 2'd1;
  localparam logic [1:0] MODE_64QAM = 2'd2;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_EMIT = 1'b1
  } state_t;

  // Mode 3 is reserved and falls back to 16-QAM.
  function automatic logic [2:0] bits_per_sym(input logic [1:0] mode);
    case (mode)
      MODE_QPSK:  return 3'd2;
      MODE_64QAM: return 3'd6;
      default:    return 3'd4;
    endcase
  endfunction

  // grp holds hb bits right-aligned, first-received bit is the sign (1 = +).
  function automatic logic signed [3:0] axis_map(input logic [1:0] hb, input logic [2:0] grp);
    logic       sign;
    logic [1:0] g;
    logic [1:0] b;
    logic [3:0] mag;
    case (hb)
      2'd1: begin
        sign = grp[0];
        g    = 2'b00;
      end
      2'd2: begin
        sign = grp[1];
        g    = {1'b0, grp[0]};
      end
      default: begin
        sign = grp[2];
        g    = grp[1:0];
      end
    endcase
    b   = {g[1], g[1] ^ g[0]};
    mag = {1'b0, b, 1'b1};
    return sign ? $signed(mag) : -$signed(mag);
  endfunction

endpackage

// File: rtl/qam_sym_buf.sv
// qam_sym_buf: one frame of complex symbols, single write port and
// combinational read port.
module qam_sym_buf #(
  parameter int DEPTH = 64,
  parameter int AW    = 6,
  parameter int W     = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic signed [W-1:0] wr_re,
  input  logic signed [W-1:0] wr_im,
  input  logic [AW-1:0]       rd_addr,
  output logic signed [W-1:0] rd_re,
  output logic signed [W-1:0] rd_im
);

  logic [2*W-1:0] mem [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_addr] <= {wr_re, wr_im};
    end
  end

  assign rd_re = $signed(mem[rd_addr][2*W-1:W]);
  assign rd_im = $signed(mem[rd_addr][W-1:0]);

endmodule

// File: rtl/qam_herm_mapper.sv
// qam_herm_mapper: serial-bit QPSK/16/64-QAM mapper emitting one Hermitian-symmetric
// frame of NFFT samples per symbol. Define QAM_DC_NULL_EN to leave subcarrier 0 empty.
module qam_herm_mapper
  import qam_map_pkg::*;
#(
  parameter int NFFT = 128,
  parameter int W    = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          mode,
  input  logic                data_in,
  input  logic                data_valid,
  output logic                data_ready,
  output logic signed [W-1:0] I_real,
  output logic signed [W-1:0] Q_imag,
  input  logic                sink_ready,
  output logic                sink_valid,
  output logic                sink_sop,
  output logic                sink_eop
);

  // state | meaning
  // FILL  | accepting serial bits, writing completed symbols to the buffer
  // EMIT  | streaming the mirrored frame to the IFFT sink, input stalled

  localparam int KW = $clog2(NFFT);
  localparam int AW = KW - 1;
`ifdef QAM_DC_NULL_EN
  localparam logic DC_NULL = 1'b1;
`else
  localparam logic DC_NULL = 1'b0;
`endif
  localparam logic [AW-1:0] FIRST_IDX = DC_NULL ? AW'(1) : AW'(0);
  localparam logic [AW-1:0] LAST_IDX  = AW'(NFFT/2 - 1);

  state_t              state;
  logic [1:0]          mode_q;
  logic [4:0]          sh;
  logic [2:0]          bits_left;
  logic [AW-1:0]       sym_idx;
  logic                wr_en;
  logic [AW-1:0]       wr_addr;
  logic signed [W-1:0] wr_re;
  logic signed [W-1:0] wr_im;
  logic [KW-1:0]       k;

  logic                accept;
  logic [5:0]          full;
  logic [1:0]          hb;
  logic [2:0]          grp_i;
  logic [2:0]          grp_q;
  logic signed [3:0]   ax_i;
  logic signed [3:0]   ax_q;
  logic signed [W-1:0] sym_re;
  logic signed [W-1:0] sym_im;

  logic [AW-1:0]       rd_addr;
  logic signed [W-1:0] rd_re;
  logic signed [W-1:0] rd_im;
  logic signed [W-1:0] smp_re;
  logic signed [W-1:0] smp_im;

  assign accept = data_valid && data_ready;
  assign full   = {sh, data_in};
  assign hb     = 2'(bits_per_sym(mode_q) >> 1);

  always_comb begin
    grp_i = '0;
    grp_q = '0;
    case (hb)
      2'd1: begin
        grp_i = {2'b00, full[1]};
        grp_q = {2'b00, full[0]};
      end
      2'd2: begin
        grp_i = {1'b0, full[3:2]};
        grp_q = {1'b0, full[1:0]};
      end
      default: begin
        grp_i = full[5:3];
        grp_q = full[2:0];
      end
    endcase
  end

  assign ax_i   = axis_map(hb, grp_i);
  assign ax_q   = axis_map(hb, grp_q);
  assign sym_re = W'(ax_i);
  assign sym_im = W'(ax_q);

  // Upper half of the frame reads the mirrored index NFFT-k.
  assign rd_addr = k[KW-1] ? AW'(-k) : k[AW-1:0];

  always_comb begin
    smp_re = rd_re;
    smp_im = rd_im;
    if (k[AW-1:0] == '0) begin
      smp_re = DC_NULL ? '0 : (k[KW-1] ? rd_im : rd_re);
      smp_im = '0;
    end else if (k[KW-1]) begin
      smp_im = -rd_im;
    end
  end

  qam_sym_buf #(
    .DEPTH (NFFT/2),
    .AW    (AW),
    .W     (W)
  ) u_buf (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_re   (wr_re),
    .wr_im   (wr_im),
    .rd_addr (rd_addr),
    .rd_re   (rd_re),
    .rd_im   (rd_im)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_FILL;
      mode_q     <= MODE_QPSK;
      sh         <= '0;
      bits_left  <= '0;
      sym_idx    <= FIRST_IDX;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_re      <= '0;
      wr_im      <= '0;
      k          <= '0;
      data_ready <= 1'b0;
      I_real     <= '0;
      Q_imag     <= '0;
      sink_valid <= 1'b0;
      sink_sop   <= 1'b0;
      sink_eop   <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      case (state)
        ST_FILL: begin
          // Idle FILL with no pending write only happens right after reset.
          if (!data_ready && !wr_en) begin
            data_ready <= 1'b1;
            mode_q     <= mode;
            bits_left  <= bits_per_sym(mode) - 3'd1;
            sym_idx    <= FIRST_IDX;
          end else if (accept) begin
            sh <= full[4:0];
            if (bits_left == '0) begin
              wr_en     <= 1'b1;
              wr_addr   <= sym_idx;
              wr_re     <= sym_re;
              wr_im     <= sym_im;
              bits_left <= bits_per_sym(mode_q) - 3'd1;
              sym_idx   <= sym_idx + 1'b1;
              if (sym_idx == LAST_IDX) data_ready <= 1'b0;
            end else begin
              bits_left <= bits_left - 3'd1;
            end
          end
          if (wr_en && wr_addr == LAST_IDX) state <= ST_EMIT;
        end
        ST_EMIT: begin
          if (!sink_valid || sink_ready) begin
            if (sink_valid && sink_eop) begin
              state      <= ST_FILL;
              sink_valid <= 1'b0;
              sink_sop   <= 1'b0;
              sink_eop   <= 1'b0;
              k          <= '0;
              data_ready <= 1'b1;
              mode_q     <= mode;
              bits_left  <= bits_per_sym(mode) - 3'd1;
              sym_idx    <= FIRST_IDX;
            end else begin
              I_real     <= smp_re;
              Q_imag     <= smp_im;
              sink_valid <= 1'b1;
              sink_sop   <= (k == '0);
              sink_eop   <= (&k);
              k          <= k + 1'b1;
            end
          end
        end
        default: state <= ST_FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_qam_herm_mapper.sv
// tb_qam_herm_mapper: random frames against a behavioural Hermitian-frame model,
// plus directed stall, mode-switch and mid-frame reset scenarios.
`timescale 1ns/1ps
module tb_qam_herm_mapper;

  localparam int NFFT   = 8;
  localparam int W      = 8;
  localparam int S_HALF = NFFT/2;
`ifdef QAM_DC_NULL_EN
  localparam int FIRST = 1;
  int lit_re[NFFT] = '{0, -1, 3, 1, 0, 1, 3, -1};
  int lit_im[NFFT] = '{0, -1, 3, 1, 0, -1, -3, 1};
`else
  localparam int FIRST = 0;
  int lit_re[NFFT] = '{-1, 3, 1, -3, -1, -3, 1, 3};
  int lit_im[NFFT] = '{0, 3, 1, -3, 0, 3, -1, -3};
`endif
  localparam int NSYM = S_HALF - FIRST;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic [1:0]          mode = 2'd1;
  logic                data_in = 1'b0;
  logic                data_valid = 1'b0;
  logic                data_ready;
  logic signed [W-1:0] I_real;
  logic signed [W-1:0] Q_imag;
  logic                sink_ready = 1'b0;
  logic                sink_valid;
  logic                sink_sop;
  logic                sink_eop;

  int checks = 0;
  int failures = 0;
  int exp_re[NFFT];
  int exp_im[NFFT];
  int bits[64];
  int kexp = 0;
  int frames_done = 0;
  int bp_mode = 0;
  int stall_cnt = 0;
  int prev_re = 0;
  int prev_im = 0;
  bit prev_stall = 1'b0;

  always #5 clk = ~clk;

  qam_herm_mapper #(.NFFT(NFFT), .W(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .mode       (mode),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .I_real     (I_real),
    .Q_imag     (Q_imag),
    .sink_ready (sink_ready),
    .sink_valid (sink_valid),
    .sink_sop   (sink_sop),
    .sink_eop   (sink_eop)
  );

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, expv);
    end
  endtask

  function automatic int bps_of(input int m);
    return (m == 0) ? 2 : ((m == 2) ? 6 : 4);
  endfunction

  // Sign bit first, then Gray-coded magnitude index.
  function automatic int axis_val(input int hb, input int grp);
    int sgn;
    int g;
    int b;
    sgn = (grp >> (hb - 1)) & 1;
    g   = grp & ((1 << (hb - 1)) - 1);
    b   = 0;
    for (int t = g; t != 0; t = t >> 1) b = b ^ t;
    return (sgn != 0) ? (2*b + 1) : -(2*b + 1);
  endfunction

  task automatic build_expected(input int fmode);
    int hb;
    int p;
    int gi;
    int gq;
    int xr[S_HALF];
    int xi[S_HALF];
    hb = bps_of(fmode) / 2;
    p  = 0;
    for (int s = 0; s < S_HALF; s++) begin
      xr[s] = 0;
      xi[s] = 0;
    end
    for (int s = FIRST; s < S_HALF; s++) begin
      gi = 0;
      gq = 0;
      for (int j = 0; j < hb; j++) begin gi = gi*2 + bits[p]; p++; end
      for (int j = 0; j < hb; j++) begin gq = gq*2 + bits[p]; p++; end
      xr[s] = axis_val(hb, gi);
      xi[s] = axis_val(hb, gq);
    end
    for (int k = 0; k < NFFT; k++) begin
      if (k == 0) begin
        exp_re[k] = (FIRST == 1) ? 0 : xr[0];
        exp_im[k] = 0;
      end else if (k < S_HALF) begin
        exp_re[k] = xr[k];
        exp_im[k] = xi[k];
      end else if (k == S_HALF) begin
        exp_re[k] = (FIRST == 1) ? 0 : xi[0];
        exp_im[k] = 0;
      end else begin
        exp_re[k] = xr[NFFT-k];
        exp_im[k] = -xi[NFFT-k];
      end
    end
  endtask

  // Sample checker: every presented sample against the model, plus hold under stall.
  always @(negedge clk) begin
    if (reset) begin
      kexp       = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", int'(sink_valid), 1);
        if (sink_valid) begin
          chk("hold_i", int'(I_real), prev_re);
          chk("hold_q", int'(Q_imag), prev_im);
        end
      end
      if (sink_valid) begin
        chk($sformatf("smp_i k=%0d", kexp), int'(I_real), exp_re[kexp]);
        chk($sformatf("smp_q k=%0d", kexp), int'(Q_imag), exp_im[kexp]);
        chk($sformatf("sop k=%0d", kexp), int'(sink_sop), int'(kexp == 0));
        chk($sformatf("eop k=%0d", kexp), int'(sink_eop), int'(kexp == NFFT-1));
        chk("ready_low_emit", int'(data_ready), 0);
        prev_re    = int'(I_real);
        prev_im    = int'(Q_imag);
        prev_stall = !sink_ready;
        if (sink_ready) begin
          kexp++;
          if (kexp == NFFT) begin
            kexp = 0;
            frames_done++;
          end
        end
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  always begin
    @(posedge clk);
    #1;
    case (bp_mode)
      0: sink_ready = 1'b1;
      1: sink_ready = ($urandom_range(0, 2) != 0);
      default: begin
        if (sink_valid && kexp == 3 && stall_cnt < 3) begin
          sink_ready = 1'b0;
          stall_cnt++;
        end else begin
          sink_ready = 1'b1;
        end
      end
    endcase
  end

  // Drives one frame of bits; mode switches to nmode halfway through the fill.
  task automatic fill_frame(input int fmode, input int nmode, input bit rnd);
    int nb;
    int idx;
    int budget;
    nb = NSYM * bps_of(fmode);
    if (rnd) for (int i = 0; i < nb; i++) bits[i] = int'($urandom_range(0, 1));
    build_expected(fmode);
    idx    = 0;
    budget = 0;
    while (idx < nb && budget < 2000) begin
      @(posedge clk);
      #1;
      if (idx >= nb/2) mode = 2'(nmode);
      data_valid = ($urandom_range(0, 3) != 0);
      data_in    = bits[idx][0];
      @(negedge clk);
      if (data_valid && data_ready) idx++;
      budget++;
    end
    chk("fill_bits", idx, nb);
    @(posedge clk);
    #1;
    data_valid = 1'b1;
    data_in    = 1'($urandom_range(0, 1));
    @(negedge clk);
    chk("valid_at_last_bit", int'(sink_valid), 0);
    @(negedge clk);
    chk("valid_edge1", int'(sink_valid), 0);
    @(negedge clk);
    chk("valid_edge2", int'(sink_valid), 1);
    data_valid = 1'b0;
  endtask

  task automatic wait_frame(input int tgt);
    int budget;
    budget = 0;
    while (frames_done < tgt && budget < 500) begin
      @(posedge clk);
      #1;
      budget++;
    end
    chk("frame_done", frames_done, tgt);
  endtask

  initial begin
    int prev_m;
    int nm;
    int tgt;
    int b;
    int seq[16] = '{0,0,0,0,1,1,1,1,1,0,1,0,0,1,0,1};

    reset = 1'b1;
    mode  = 2'd1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_i", int'(I_real), 0);
    chk("rst_q", int'(Q_imag), 0);
    chk("rst_valid", int'(sink_valid), 0);
    chk("rst_sop", int'(sink_sop), 0);
    chk("rst_eop", int'(sink_eop), 0);
    chk("rst_ready", int'(data_ready), 0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("ready_after_release", int'(data_ready), 0);
    @(posedge clk);
    #1;
    chk("ready_rise", int'(data_ready), 1);

    // Directed frame: fixed 16-QAM bits, stall at k=3, mode goes to 64-QAM mid-fill.
    for (int i = 0; i < 16; i++) bits[i] = seq[i];
    bp_mode   = 2;
    stall_cnt = 0;
    tgt = frames_done + 1;
    fill_frame(1, 2, 1'b0);
    for (int k = 0; k < NFFT; k++) begin
      chk($sformatf("lit_re k=%0d", k), exp_re[k], lit_re[k]);
      chk($sformatf("lit_im k=%0d", k), exp_im[k], lit_im[k]);
    end
    chk("lit_64qam_i", axis_val(3, 7), 5);
    chk("lit_64qam_q", axis_val(3, 2), -7);
    chk("lit_qpsk_i", axis_val(1, 1), 1);
    chk("lit_qpsk_q", axis_val(1, 0), -1);
    chk("lit_16qam_01", axis_val(2, 1), -3);
    wait_frame(tgt);
    chk("stall_cycles", stall_cnt, 3);

    bp_mode = 1;
    prev_m  = 2;
    for (int f = 0; f < 6; f++) begin
      nm  = int'($urandom_range(0, 3));
      tgt = frames_done + 1;
      fill_frame(prev_m, nm, 1'b1);
      wait_frame(tgt);
      prev_m = nm;
    end

    // Reset while sample k=5 is on the bus.
    bp_mode = 0;
    nm = int'($urandom_range(0, 3));
    fill_frame(prev_m, nm, 1'b1);
    b = 0;
    while (!(sink_valid && kexp == 5) && b < 200) begin
      @(posedge clk);
      #1;
      b++;
    end
    chk("reach_k5", kexp, 5);
    reset = 1'b1;
    #1;
    chk("mid_rst_i", int'(I_real), 0);
    chk("mid_rst_q", int'(Q_imag), 0);
    chk("mid_rst_valid", int'(sink_valid), 0);
    chk("mid_rst_sop", int'(sink_sop), 0);
    chk("mid_rst_eop", int'(sink_eop), 0);
    chk("mid_rst_ready", int'(data_ready), 0);
    prev_m = int'($urandom_range(0, 3));
    mode   = 2'(prev_m);
    @(negedge clk);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_ready_after_release", int'(data_ready), 0);
    @(posedge clk);
    #1;
    chk("mid_ready_rise", int'(data_ready), 1);

    bp_mode = 1;
    for (int f = 0; f < 3; f++) begin
      nm  = int'($urandom_range(0, 3));
      tgt = frames_done + 1;
      fill_frame(prev_m, nm, 1'b1);
      wait_frame(tgt);
      prev_m = nm;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
